// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the architectural PC, fetches over a req/ack
// handshake, holds one instruction for decode and resolves the next PC on retire.
module fetch_unit #(
  parameter int               XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC  = 32'h0000_0000,
  parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            pcsrc,
  input  logic            jbmux,
  input  logic [XLEN-1:0] immext,
  input  logic [XLEN-1:0] alu_result,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ack,
  output logic [31:0]     instr,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pcplus4,
  output logic            misalign_err
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_ERR   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            instr_valid_q, instr_valid_d;
  logic            misalign_err_q, misalign_err_d;

  logic [XLEN-1:0] pcplus4_w;
  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] next_pc;

  assign pcplus4_w     = pc_q + XLEN'(4);
  // jalr clears bit 0 of the computed address; bit 1 is left for the alignment check
  assign branch_target = jbmux ? (alu_result & ~XLEN'(1)) : (pc_q + immext);
  assign next_pc       = pcsrc ? branch_target : pcplus4_w;

  always_comb begin
    state_d        = state_q;
    fetch_pc_d     = fetch_pc_q;
    pc_d           = pc_q;
    instr_d        = instr_q;
    instr_valid_d  = instr_valid_q;
    misalign_err_d = misalign_err_q;
    imem_req       = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_d       = imem_rdata;
          pc_d          = fetch_pc_q;
          instr_valid_d = 1'b1;
          state_d       = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!stall) begin
          instr_valid_d = 1'b0;
          instr_d       = NOP_INSTR;
          if (next_pc[1:0] == 2'b00) begin
            fetch_pc_d = next_pc;
            state_d    = S_FETCH;
          end else begin
            misalign_err_d = 1'b1;
            state_d        = S_ERR;
          end
        end
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_FETCH;
      fetch_pc_q     <= RESET_PC;
      pc_q           <= RESET_PC;
      instr_q        <= NOP_INSTR;
      instr_valid_q  <= 1'b0;
      misalign_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      fetch_pc_q     <= fetch_pc_d;
      pc_q           <= pc_d;
      instr_q        <= instr_d;
      instr_valid_q  <= instr_valid_d;
      misalign_err_q <= misalign_err_d;
    end
  end

  assign imem_addr    = fetch_pc_q;
  assign instr        = instr_q;
  assign instr_valid  = instr_valid_q;
  assign pc           = pc_q;
  assign pcplus4      = pcplus4_w;
  assign misalign_err = misalign_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: the bench plays instruction memory and checks each
// fetch/retire against PC rules evaluated with plain arithmetic.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        pcsrc = 1'b0;
  logic        jbmux = 1'b0;
  logic [31:0] immext = '0;
  logic [31:0] alu_result = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_ack = 1'b0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pcplus4;
  logic        misalign_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .pcsrc(pcsrc), .jbmux(jbmux),
    .immext(immext), .alu_result(alu_result),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .instr(instr), .instr_valid(instr_valid), .pc(pc), .pcplus4(pcplus4),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; imem_ack = 1'b0; pcsrc = 1'b0; jbmux = 1'b0;
    step();
    step();
    rst = 1'b0;
    cyc = 0;
  endtask

  // Memory side of one fetch: ack after lat wait cycles with word.
  // clean reports whether req/addr stayed stable and no valid appeared before ack.
  task automatic fetch_txn(input int lat, input logic [31:0] word,
                           output logic [31:0] addr0, output bit clean);
    clean = 1'b1;
    addr0 = imem_addr;
    for (int i = 0; i < lat; i++) begin
      imem_ack = 1'b0;
      if (imem_req !== 1'b1 || imem_addr !== addr0 || instr_valid !== 1'b0) clean = 1'b0;
      step();
    end
    if (imem_req !== 1'b1 || imem_addr !== addr0 || instr_valid !== 1'b0) clean = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = word;
    step();
    imem_ack = 1'b0;
    imem_rdata = $urandom;
  endtask

  // Decode side: stall for stall_n cycles with noisy inputs, then retire.
  // held reports whether instr/pc/valid stayed put with no request during the stall.
  task automatic retire_txn(input int stall_n, input bit ps, input bit jb,
                            input logic [31:0] imm, input logic [31:0] alu, output bit held);
    logic [31:0] i0, p0;
    held = (instr_valid === 1'b1);
    i0 = instr;
    p0 = pc;
    stall = 1'b1;
    for (int i = 0; i < stall_n; i++) begin
      pcsrc = i[0]; jbmux = 1'($urandom); immext = $urandom; alu_result = $urandom;
      imem_ack = 1'($urandom); imem_rdata = $urandom;
      step();
      if (instr !== i0 || pc !== p0 || instr_valid !== 1'b1 || imem_req !== 1'b0) held = 1'b0;
    end
    imem_ack = 1'b0;
    stall = 1'b0; pcsrc = ps; jbmux = jb; immext = imm; alu_result = alu;
    step();
    pcsrc = 1'b0; jbmux = 1'b0;
  endtask

  // Fetch whatever is requested, then jump to addr via jalr.
  task automatic goto_pc(input logic [31:0] addr);
    logic [31:0] a;
    bit c, h;
    fetch_txn(0, $urandom, a, c);
    retire_txn(0, 1'b1, 1'b1, 32'h0, addr, h);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
    total++; if (instr !== NOP) begin bad++; $display("FAIL reset_instr got=%h exp=%h", instr, NOP); end
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", pc); end
    total++; if (pcplus4 !== 32'h4) begin bad++; $display("FAIL reset_pcplus4 got=%h exp=4", pcplus4); end
    total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", misalign_err); end
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL reset_req got=%b/%h exp=1/0", imem_req, imem_addr); end
    $display("reset: pc=%h instr=%h", pc, instr);
  endtask

  task automatic test_zero_wait();
    logic [31:0] a;
    bit c, h;
    do_reset();
    fetch_txn(0, 32'h0050_0093, a, c);
    total++; if (a !== 32'h0 || !c) begin bad++; $display("FAIL zw_addr0 got=%h clean=%0d exp=0", a, c); end
    total++; if (cyc !== 1 || instr_valid !== 1'b1) begin bad++; $display("FAIL zw_valid0 got cyc=%0d v=%b exp cyc=1 v=1", cyc, instr_valid); end
    total++; if (pc !== 32'h0 || instr !== 32'h0050_0093 || pcplus4 !== 32'h4) begin bad++; $display("FAIL zw_out0 got pc=%h i=%h p4=%h", pc, instr, pcplus4); end
    retire_txn(0, 1'b0, 1'b0, 32'h0, 32'h0, h);
    fetch_txn(0, 32'h0010_0113, a, c);
    total++; if (a !== 32'h4 || !c) begin bad++; $display("FAIL zw_addr1 got=%h clean=%0d exp=4", a, c); end
    total++; if (cyc !== 3 || instr_valid !== 1'b1) begin bad++; $display("FAIL zw_valid1 got cyc=%0d v=%b exp cyc=3 v=1", cyc, instr_valid); end
    total++; if (pc !== 32'h4 || instr !== 32'h0010_0113 || pcplus4 !== 32'h8) begin bad++; $display("FAIL zw_out1 got pc=%h i=%h p4=%h", pc, instr, pcplus4); end
    $display("zero_wait: second pc=%h instr=%h", pc, instr);
  endtask

  task automatic test_latency();
    logic [31:0] a;
    bit c;
    do_reset();
    fetch_txn(3, 32'hCAFE_0013, a, c);
    total++; if (!c || a !== 32'h0) begin bad++; $display("FAIL lat_stable clean=%0d addr=%h exp clean=1 addr=0", c, a); end
    total++; if (cyc !== 4 || instr_valid !== 1'b1) begin bad++; $display("FAIL lat_valid got cyc=%0d v=%b exp cyc=4 v=1", cyc, instr_valid); end
    total++; if (pc !== 32'h0 || instr !== 32'hCAFE_0013) begin bad++; $display("FAIL lat_out got pc=%h i=%h", pc, instr); end
    $display("latency: pc=%h instr=%h after %0d cycles", pc, instr, cyc);
  endtask

  task automatic test_branch();
    logic [31:0] a;
    bit c, h;
    do_reset();
    goto_pc(32'h10);
    fetch_txn(1, $urandom, a, c);
    total++; if (pc !== 32'h10) begin bad++; $display("FAIL br_pc got=%h exp=10", pc); end
    retire_txn(0, 1'b1, 1'b0, 32'hFFFF_FFF8, $urandom, h);
    total++; if (imem_addr !== 32'h8 || imem_req !== 1'b1) begin bad++; $display("FAIL br_taken got=%h exp=8", imem_addr); end
    goto_pc(32'h10);
    fetch_txn(0, $urandom, a, c);
    retire_txn(0, 1'b0, 1'b0, 32'hFFFF_FFF8, $urandom, h);
    total++; if (imem_addr !== 32'h14) begin bad++; $display("FAIL br_not_taken got=%h exp=14", imem_addr); end
    $display("branch: not-taken fetch at %h", imem_addr);
  endtask

  task automatic test_jalr();
    logic [31:0] a;
    bit c, h, req_seen, err_drop;
    do_reset();
    goto_pc(32'h20);
    fetch_txn(0, $urandom, a, c);
    retire_txn(0, 1'b1, 1'b1, $urandom, 32'h101, h);
    total++; if (imem_addr !== 32'h100 || misalign_err !== 1'b0) begin bad++; $display("FAIL jalr_bit0 got=%h err=%b exp=100", imem_addr, misalign_err); end
    goto_pc(32'h20);
    fetch_txn(0, $urandom, a, c);
    retire_txn(0, 1'b1, 1'b1, $urandom, 32'h102, h);
    total++; if (misalign_err !== 1'b1) begin bad++; $display("FAIL jalr_err got=%b exp=1", misalign_err); end
    total++; if (instr_valid !== 1'b0 || instr !== NOP || pc !== 32'h20) begin bad++; $display("FAIL jalr_err_out got v=%b i=%h pc=%h", instr_valid, instr, pc); end
    req_seen = 1'b0;
    err_drop = 1'b0;
    for (int i = 0; i < 10; i++) begin
      stall = 1'($urandom); imem_ack = 1'($urandom); pcsrc = 1'($urandom);
      step();
      if (imem_req !== 1'b0 || instr_valid !== 1'b0) req_seen = 1'b1;
      if (misalign_err !== 1'b1) err_drop = 1'b1;
    end
    total++; if (req_seen) begin bad++; $display("FAIL err_quiet got req/valid activity exp none"); end
    total++; if (err_drop) begin bad++; $display("FAIL err_sticky got drop exp held 1"); end
    do_reset();
    total++; if (misalign_err !== 1'b0 || imem_req !== 1'b1) begin bad++; $display("FAIL err_clear got err=%b req=%b", misalign_err, imem_req); end
    $display("jalr: error state entered and cleared by reset");
  endtask

  task automatic test_stall();
    logic [31:0] a, w;
    bit c, h;
    do_reset();
    goto_pc(32'h30);
    w = $urandom;
    fetch_txn(0, w, a, c);
    retire_txn(5, 1'b0, 1'b1, $urandom, $urandom, h);
    total++; if (!h) begin bad++; $display("FAIL stall_hold got changes exp instr=%h pc=30 held", w); end
    total++; if (imem_addr !== 32'h34 || imem_req !== 1'b1) begin bad++; $display("FAIL stall_release got=%h exp=34", imem_addr); end
    $display("stall: released to fetch %h", imem_addr);
  endtask

  task automatic test_reset_mid_fetch();
    logic [31:0] a, w;
    bit c;
    do_reset();
    goto_pc(32'h40);
    imem_ack = 1'b0;
    step();
    step();
    total++; if (imem_addr !== 32'h40 || imem_req !== 1'b1) begin bad++; $display("FAIL mid_pre got=%h exp=40", imem_addr); end
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    total++; if (imem_addr !== 32'h0 || instr_valid !== 1'b0 || instr !== NOP || pc !== 32'h0) begin bad++; $display("FAIL mid_rst got a=%h v=%b i=%h pc=%h", imem_addr, instr_valid, instr, pc); end
    rst = 1'b0; imem_ack = 1'b0;
    w = $urandom;
    fetch_txn(0, w, a, c);
    total++; if (pc !== 32'h0 || instr !== w) begin bad++; $display("FAIL mid_after got pc=%h i=%h exp 0/%h", pc, instr, w); end
    $display("reset_mid_fetch: refetch pc=%h", pc);
  endtask

  task automatic test_wrap();
    logic [31:0] a;
    bit c, h;
    do_reset();
    goto_pc(32'hFFFF_FFFC);
    fetch_txn(2, $urandom, a, c);
    total++; if (pc !== 32'hFFFF_FFFC || pcplus4 !== 32'h0) begin bad++; $display("FAIL wrap_p4 got pc=%h p4=%h exp fffffffc/0", pc, pcplus4); end
    retire_txn(1, 1'b0, 1'b0, $urandom, $urandom, h);
    total++; if (imem_addr !== 32'h0 || misalign_err !== 1'b0) begin bad++; $display("FAIL wrap_fetch got=%h err=%b exp 0/0", imem_addr, misalign_err); end
    $display("wrap: fetch %h", imem_addr);
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, a, w, imm, alu, r, tgt, nxt;
    bit c, h, ps, jb;
    int lat, st;
    do_reset();
    exp_pc = 32'h0;
    for (int n = 0; n < 60; n++) begin
      lat = $urandom_range(0, 3);
      st  = $urandom_range(0, 3);
      w   = $urandom;
      fetch_txn(lat, w, a, c);
      total++; if (a !== exp_pc || !c) begin bad++; $display("FAIL rnd_fetch n=%0d got=%h clean=%0d exp=%h", n, a, c, exp_pc); end
      total++; if (instr_valid !== 1'b1 || pc !== exp_pc || instr !== w || pcplus4 !== exp_pc + 32'd4) begin bad++; $display("FAIL rnd_out n=%0d got v=%b pc=%h i=%h p4=%h exp pc=%h i=%h", n, instr_valid, pc, instr, pcplus4, exp_pc, w); end
      ps = 1'($urandom);
      jb = 1'($urandom);
      r = $urandom;
      imm = ($urandom_range(0, 7) == 0) ? r : {{20{r[11]}}, r[11:2], 2'b00};
      r = $urandom;
      alu = ($urandom_range(0, 7) == 0) ? r : ({r[31:2], 2'b00} | {31'b0, r[0]});
      tgt = jb ? {alu[31:1], 1'b0} : exp_pc + imm;
      nxt = ps ? tgt : exp_pc + 32'd4;
      retire_txn(st, ps, jb, imm, alu, h);
      total++; if (!h) begin bad++; $display("FAIL rnd_hold n=%0d instr/pc moved during stall", n); end
      $display("txn %0d: pc=%h instr=%h pcsrc=%0d jbmux=%0d next=%h", n, exp_pc, w, ps, jb, nxt);
      if (nxt[1:0] != 2'b00) begin
        total++; if (misalign_err !== 1'b1 || instr_valid !== 1'b0 || pc !== exp_pc || imem_req !== 1'b0) begin bad++; $display("FAIL rnd_err n=%0d got err=%b v=%b pc=%h req=%b exp 1/0/%h/0", n, misalign_err, instr_valid, pc, imem_req, exp_pc); end
        do_reset();
        exp_pc = 32'h0;
      end else begin
        total++; if (imem_addr !== nxt || imem_req !== 1'b1 || misalign_err !== 1'b0) begin bad++; $display("FAIL rnd_next n=%0d got=%h err=%b exp=%h", n, imem_addr, misalign_err, nxt); end
        exp_pc = nxt;
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_latency();
    test_branch();
    test_jalr();
    test_stall();
    test_reset_mid_fetch();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
